// File: rtl/uart_seq_pkg.sv
// rtl/uart_seq_pkg.sv - shared types, command codes and constants for the UART command sequencer
package uart_seq_pkg;

    typedef enum logic [2:0] {
        S_RX,
        S_ACK,
        S_ISSUE,
        S_EXEC,
        S_TX
    } state_t;

    // Packet is cmd + op1[31:0] + op2[31:0]; fixed by the host protocol.
    localparam int PKT_BYTES = 9;

    localparam logic [7:0] CMD_ADD   = 8'h61; // 'a'
    localparam logic [7:0] CMD_SUB   = 8'h73; // 's'
    localparam logic [7:0] CMD_MUL   = 8'h6D; // 'm'
    localparam logic [7:0] CMD_MULH  = 8'h4D; // 'M'
    localparam logic [7:0] CMD_DIV   = 8'h64; // 'd'
    localparam logic [7:0] CMD_XOR   = 8'h78; // 'x'
    localparam logic [7:0] CMD_LOAD  = 8'h6C; // 'l'
    localparam logic [7:0] CMD_STORE = 8'h75; // 'u'
    localparam logic [7:0] CMD_ONE   = 8'h31; // '1'
    localparam logic [7:0] CMD_TWO   = 8'h32; // '2'
    localparam logic [7:0] CMD_FIVE  = 8'h35; // '5'

    localparam int ERR_RX_TIMEOUT   = 0;
    localparam int ERR_ILLEGAL_CMD  = 1;
    localparam int ERR_EXEC_TIMEOUT = 2;

    localparam logic [31:0] RESULT_ILLEGAL = 32'hFFFF_FFFF;
    localparam logic [31:0] RESULT_TIMEOUT = 32'hDEAD_DEAD;

    function automatic logic cmd_is_legal(input logic [7:0] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_MUL, CMD_MULH, CMD_DIV, CMD_XOR,
            CMD_LOAD, CMD_STORE, CMD_ONE, CMD_TWO, CMD_FIVE: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_packer.sv
// rtl/uart_rx_packer.sv - four-phase RX byte collector building the 9-byte command packet
// Ports: clk/rst_n (async active-low); enable (sequencer is in an RX phase); clear (drop byte count);
//        rx_data/rx_valid/rx_ack host handshake; byte_cnt; byte_taken, ack_done, packet_ready and
//        rx_timeout single-cycle event strobes; packet = {cmd, op1, op2}.
module uart_rx_packer
    import uart_seq_pkg::*;
#(
    parameter int RX_TIMEOUT = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ack,
    output logic [3:0]               byte_cnt,
    output logic                     byte_taken,
    output logic                     ack_done,
    output logic                     packet_ready,
    output logic                     rx_timeout,
    output logic [8*PKT_BYTES-1:0]   packet
);
    localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);

    logic                   ack_q, ack_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [8*PKT_BYTES-1:0] pkt_q, pkt_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;

    always_comb begin
        ack_d        = ack_q;
        cnt_d        = cnt_q;
        pkt_d        = pkt_q;
        idle_d       = '0;
        byte_taken   = 1'b0;
        ack_done     = 1'b0;
        packet_ready = 1'b0;
        rx_timeout   = 1'b0;
        if (clear) begin
            cnt_d = 4'd0;
        end else if (enable) begin
            if (!ack_q) begin
                if (rx_valid) begin
                    pkt_d      = {pkt_q[8*PKT_BYTES-9:0], rx_data};
                    cnt_d      = cnt_q + 4'd1;
                    ack_d      = 1'b1;
                    byte_taken = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    // Idle gap inside a partial packet; the counter restarts on any byte.
                    if (idle_q == IDLE_W'(RX_TIMEOUT - 1)) begin
                        cnt_d      = 4'd0;
                        rx_timeout = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end else if (!rx_valid) begin
                ack_d        = 1'b0;
                ack_done     = 1'b1;
                packet_ready = (cnt_q == 4'(PKT_BYTES));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            cnt_q  <= 4'd0;
            pkt_q  <= '0;
            idle_q <= '0;
        end else begin
            ack_q  <= ack_d;
            cnt_q  <= cnt_d;
            pkt_q  <= pkt_d;
            idle_q <= idle_d;
        end
    end

    assign rx_ack   = ack_q;
    assign byte_cnt = cnt_q;
    assign packet   = pkt_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - UART command packet sequencer in front of the compute datapath
// Ports: CLK/RESET (async active-low); UART_RX* host byte input with four-phase ack;
//        UART_TX* result byte stream (valid/ready); OP_* datapath request/completion;
//        ComputeResult last result; BUSY; ERR_FLAGS sticky errors; PKT_COUNT completed packets.
module uart_cmd_sequencer
    import uart_seq_pkg::*;
#(
    parameter int RX_TIMEOUT   = 100000,
    parameter int EXEC_TIMEOUT = 4096
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  UART_RX,
    input  logic        UART_RX_valid,
    output logic        UART_RX_ack,
    output logic [7:0]  UART_TX,
    output logic        UART_TX_valid,
    input  logic        UART_TX_ready,
    output logic [7:0]  OP_CMD,
    output logic [31:0] OP_A,
    output logic [31:0] OP_B,
    output logic        OP_START,
    input  logic        OP_DONE,
    input  logic [31:0] OP_RESULT,
    output logic [31:0] ComputeResult,
    output logic        BUSY,
    output logic [2:0]  ERR_FLAGS,
    output logic [15:0] PKT_COUNT
);
    localparam int EXEC_W = $clog2(EXEC_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [1:0]         tx_cnt_q, tx_cnt_d;
    logic [EXEC_W-1:0]  exec_cnt_q, exec_cnt_d;
    logic [31:0]        result_q, result_d;
    logic [7:0]         op_cmd_q, op_cmd_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic               op_start_q, op_start_d;
    logic [31:0]        compute_result_q, compute_result_d;
    logic [2:0]         err_q, err_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;

    logic               rx_enable;
    logic               pkt_clear;
    logic [3:0]         byte_cnt;
    logic               byte_taken, ack_done, packet_ready, rx_timeout;
    logic [8*PKT_BYTES-1:0] packet;
    logic [7:0]         pkt_cmd;
    logic [31:0]        pkt_op1, pkt_op2;
    logic [7:0]         tx_byte;

    assign {pkt_cmd, pkt_op1, pkt_op2} = packet;
    assign rx_enable = (state_q == S_RX) || (state_q == S_ACK);

    uart_rx_packer #(
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx_packer (
        .clk          (CLK),
        .rst_n        (RESET),
        .enable       (rx_enable),
        .clear        (pkt_clear),
        .rx_data      (UART_RX),
        .rx_valid     (UART_RX_valid),
        .rx_ack       (UART_RX_ack),
        .byte_cnt     (byte_cnt),
        .byte_taken   (byte_taken),
        .ack_done     (ack_done),
        .packet_ready (packet_ready),
        .rx_timeout   (rx_timeout),
        .packet       (packet)
    );

    always_comb begin
        state_d          = state_q;
        tx_cnt_d         = tx_cnt_q;
        exec_cnt_d       = exec_cnt_q;
        result_d         = result_q;
        op_cmd_d         = op_cmd_q;
        op_a_d           = op_a_q;
        op_b_d           = op_b_q;
        op_start_d       = 1'b0;
        compute_result_d = compute_result_q;
        err_d            = err_q;
        pkt_cnt_d        = pkt_cnt_q;
        pkt_clear        = 1'b0;

        if (rx_timeout) begin
            err_d[ERR_RX_TIMEOUT] = 1'b1;
        end

        case (state_q)
            S_RX: begin
                if (byte_taken) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (ack_done) begin
                    if (packet_ready) begin
                        state_d = S_ISSUE;
                        // Decode is registered here so OP_START and the operands are
                        // presented together during the single S_ISSUE cycle.
                        if (cmd_is_legal(pkt_cmd)) begin
                            op_cmd_d   = pkt_cmd;
                            op_a_d     = pkt_op1;
                            op_b_d     = pkt_op2;
                            op_start_d = 1'b1;
                        end
                    end else begin
                        state_d = S_RX;
                    end
                end
            end
            S_ISSUE: begin
                exec_cnt_d = '0;
                tx_cnt_d   = 2'd0;
                if (op_start_q) begin
                    state_d = S_EXEC;
                end else begin
                    result_d               = RESULT_ILLEGAL;
                    err_d[ERR_ILLEGAL_CMD] = 1'b1;
                    state_d                = S_TX;
                end
            end
            S_EXEC: begin
                if (OP_DONE) begin
                    result_d = OP_RESULT;
                    state_d  = S_TX;
                end else if (exec_cnt_q == EXEC_W'(EXEC_TIMEOUT - 1)) begin
                    result_d                = RESULT_TIMEOUT;
                    err_d[ERR_EXEC_TIMEOUT] = 1'b1;
                    state_d                 = S_TX;
                end else begin
                    exec_cnt_d = exec_cnt_q + EXEC_W'(1);
                end
            end
            S_TX: begin
                if (UART_TX_ready) begin
                    if (tx_cnt_q == 2'd3) begin
                        compute_result_d = result_q;
                        pkt_cnt_d        = pkt_cnt_q + 16'd1;
                        pkt_clear        = 1'b1;
                        tx_cnt_d         = 2'd0;
                        state_d          = S_RX;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_RX;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q          <= S_RX;
            tx_cnt_q         <= 2'd0;
            exec_cnt_q       <= '0;
            result_q         <= 32'd0;
            op_cmd_q         <= 8'd0;
            op_a_q           <= 32'd0;
            op_b_q           <= 32'd0;
            op_start_q       <= 1'b0;
            compute_result_q <= 32'd0;
            err_q            <= 3'd0;
            pkt_cnt_q        <= 16'd0;
        end else begin
            state_q          <= state_d;
            tx_cnt_q         <= tx_cnt_d;
            exec_cnt_q       <= exec_cnt_d;
            result_q         <= result_d;
            op_cmd_q         <= op_cmd_d;
            op_a_q           <= op_a_d;
            op_b_q           <= op_b_d;
            op_start_q       <= op_start_d;
            compute_result_q <= compute_result_d;
            err_q            <= err_d;
            pkt_cnt_q        <= pkt_cnt_d;
        end
    end

    // Result goes out MSB first; result_q and tx_cnt_q only move on a transfer,
    // so the byte is stable while the transmitter stalls.
    always_comb begin
        case (tx_cnt_q)
            2'd0:    tx_byte = result_q[31:24];
            2'd1:    tx_byte = result_q[23:16];
            2'd2:    tx_byte = result_q[15:8];
            default: tx_byte = result_q[7:0];
        endcase
    end

    assign UART_TX       = tx_byte;
    assign UART_TX_valid = (state_q == S_TX);
    assign OP_CMD        = op_cmd_q;
    assign OP_A          = op_a_q;
    assign OP_B          = op_b_q;
    assign OP_START      = op_start_q;
    assign ComputeResult = compute_result_q;
    assign BUSY          = !((state_q == S_RX) && (byte_cnt == 4'd0));
    assign ERR_FLAGS     = err_q;
    assign PKT_COUNT     = pkt_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - scoreboard bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;
    localparam int RXT = 300;
    localparam int EXT = 200;

    logic        CLK, RESET;
    logic [7:0]  UART_RX;
    logic        UART_RX_valid, UART_RX_ack;
    logic [7:0]  UART_TX;
    logic        UART_TX_valid, UART_TX_ready;
    logic [7:0]  OP_CMD;
    logic [31:0] OP_A, OP_B;
    logic        OP_START, OP_DONE;
    logic [31:0] OP_RESULT, ComputeResult;
    logic        BUSY;
    logic [2:0]  ERR_FLAGS;
    logic [15:0] PKT_COUNT;

    uart_cmd_sequencer #(.RX_TIMEOUT(RXT), .EXEC_TIMEOUT(EXT)) dut (
        .CLK(CLK), .RESET(RESET), .UART_RX(UART_RX), .UART_RX_valid(UART_RX_valid),
        .UART_RX_ack(UART_RX_ack), .UART_TX(UART_TX), .UART_TX_valid(UART_TX_valid),
        .UART_TX_ready(UART_TX_ready), .OP_CMD(OP_CMD), .OP_A(OP_A), .OP_B(OP_B),
        .OP_START(OP_START), .OP_DONE(OP_DONE), .OP_RESULT(OP_RESULT),
        .ComputeResult(ComputeResult), .BUSY(BUSY), .ERR_FLAGS(ERR_FLAGS), .PKT_COUNT(PKT_COUNT)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [71:0] issue_q[$];
    logic [7:0]  tx_q[$];
    int          dp_lat = 1;
    bit          dp_late = 0;
    int          tx_mode = 0;
    int          tx_xfers = 0;
    int          tx_limit = 0;
    logic [15:0] exp_pkt = 16'd0;
    logic [2:0]  exp_err = 3'd0;
    logic [7:0]  legal_set [11] = '{8'h61, 8'h73, 8'h6D, 8'h4D, 8'h64, 8'h78,
                                    8'h6C, 8'h75, 8'h31, 8'h32, 8'h35};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic bit is_legal(input logic [7:0] c);
        foreach (legal_set[i]) if (legal_set[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Datapath semantics chosen by the bench; the sequencer only forwards whatever comes back.
    function automatic logic [31:0] ref_op(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (c)
            "a":     return a + b;
            "s":     return a - b;
            "m":     return p[31:0];
            "M":     return p[63:32];
            "d":     return (b == 0) ? 32'hFFFF_FFFF : a / b;
            "x":     return a ^ b;
            "l":     return a << b[4:0];
            "u":     return a >> b[4:0];
            default: return a + b + 32'(c);
        endcase
    endfunction

    // Datapath model: answers each OP_START after dp_lat cycles, or far too late.
    initial begin
        logic [7:0]  c;
        logic [31:0] a, b;
        int          lat;
        bit          late;
        OP_DONE   = 1'b0;
        OP_RESULT = 32'd0;
        forever begin
            @(negedge CLK);
            if (RESET && OP_START) begin
                c = OP_CMD; a = OP_A; b = OP_B; lat = dp_lat; late = dp_late;
                repeat (lat) @(posedge CLK);
                #1;
                OP_DONE   = 1'b1;
                OP_RESULT = late ? 32'h1234_5678 : ref_op(c, a, b);
                @(posedge CLK);
                #1;
                OP_DONE   = 1'b0;
                OP_RESULT = $urandom;
            end
        end
    end

    // Transmitter ready pattern: 0 always, 1 one-in-three, 2 random, 5 limited count.
    initial begin
        int phase;
        phase = 0;
        UART_TX_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (tx_mode)
                0:       UART_TX_ready = 1'b1;
                1:       UART_TX_ready = (phase == 0);
                2:       UART_TX_ready = 1'($urandom_range(0, 1));
                5:       UART_TX_ready = (tx_xfers < tx_limit);
                default: UART_TX_ready = 1'b0;
            endcase
            phase = (phase + 1) % 3;
        end
    end

    // Monitor: compares datapath requests and transmitted bytes against the queues.
    initial begin
        logic [71:0] e;
        logic [7:0]  eb, held;
        bit          stalled;
        stalled = 0;
        held    = 8'd0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                stalled = 0;
            end else begin
                if (OP_START) begin
                    if (issue_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL op_start: unexpected pulse cmd=%h a=%h b=%h", OP_CMD, OP_A, OP_B);
                    end else begin
                        e = issue_q.pop_front();
                        chk("op_cmd", 32'(OP_CMD), 32'(e[71:64]));
                        chk("op_a", OP_A, e[63:32]);
                        chk("op_b", OP_B, e[31:0]);
                    end
                end
                if (UART_TX_valid) begin
                    if (stalled) chk("tx_stable", 32'(UART_TX), 32'(held));
                    if (UART_TX_ready) begin
                        stalled = 0;
                        tx_xfers++;
                        if (tx_q.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL tx_byte: unexpected byte %h", UART_TX);
                        end else begin
                            eb = tx_q.pop_front();
                            chk("tx_byte", 32'(UART_TX), 32'(eb));
                        end
                    end else begin
                        stalled = 1;
                        held    = UART_TX;
                    end
                end else begin
                    stalled = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        UART_RX = b;
        UART_RX_valid = 1'b1;
        k = 0;
        do begin @(posedge CLK); #1; k++; end while (!UART_RX_ack && k < 2000);
        if (!UART_RX_ack) note_fail("rx_ack_rise");
        UART_RX_valid = 1'b0;
        k = 0;
        do begin @(posedge CLK); #1; k++; end while (UART_RX_ack && k < 2000);
        if (UART_RX_ack) note_fail("rx_ack_fall");
    endtask

    task automatic send_bytes(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b, input int n);
        logic [71:0] p;
        p = {c, a, b};
        for (int i = 0; i < n; i++) send_byte(p[71 - 8*i -: 8]);
    endtask

    task automatic expect_pkt(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                              input int lat, input bit late, output logic [31:0] r);
        dp_lat  = lat;
        dp_late = late;
        if (!is_legal(c)) begin
            r = 32'hFFFF_FFFF;
        end else begin
            issue_q.push_back({c, a, b});
            r = late ? 32'hDEAD_DEAD : ref_op(c, a, b);
        end
        for (int i = 3; i >= 0; i--) tx_q.push_back(8'(r >> (8*i)));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin @(posedge CLK); #1; k++; end while (BUSY && k < EXT + 2000);
        if (BUSY) note_fail("wait_idle");
    endtask

    task automatic run_pkt(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input bit late);
        logic [31:0] r;
        expect_pkt(c, a, b, lat, late, r);
        send_bytes(c, a, b, 9);
        wait_idle();
        if (!is_legal(c)) exp_err[1] = 1'b1;
        else if (late)    exp_err[2] = 1'b1;
        exp_pkt = exp_pkt + 16'd1;
        chk("compute_result", ComputeResult, r);
        chk("pkt_count", 32'(PKT_COUNT), 32'(exp_pkt));
        chk("err_flags", 32'(ERR_FLAGS), 32'(exp_err));
        chk("tx_bytes_left", tx_q.size(), 0);
        chk("issues_left", issue_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, 32'(UART_RX_ack), 0);
        chk({tag, "_tx"}, 32'(UART_TX), 0);
        chk({tag, "_tx_valid"}, 32'(UART_TX_valid), 0);
        chk({tag, "_op_cmd"}, 32'(OP_CMD), 0);
        chk({tag, "_op_a"}, OP_A, 0);
        chk({tag, "_op_b"}, OP_B, 0);
        chk({tag, "_op_start"}, 32'(OP_START), 0);
        chk({tag, "_result"}, ComputeResult, 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_err"}, 32'(ERR_FLAGS), 0);
        chk({tag, "_pkt_count"}, 32'(PKT_COUNT), 0);
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        UART_RX_valid = 1'b0;
        issue_q.delete();
        tx_q.delete();
        exp_pkt = 16'd0;
        exp_err = 3'd0;
    endtask

    initial begin
        logic [7:0]  c;
        logic [31:0] r;
        int          k;
        UART_RX = 8'd0;
        UART_RX_valid = 1'b0;
        apply_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        RESET = 1'b1;

        tx_mode = 0;
        run_pkt("s", 32'd9, 32'd5, 3, 0);
        tx_mode = 1;
        run_pkt("s", 32'd9, 32'd5, 3, 0);
        tx_mode = 0;
        run_pkt("z", 32'd1, 32'd2, 2, 0);

        send_bytes("a", 32'd0, 32'd0, 4);
        chk("partial_busy", 32'(BUSY), 1);
        repeat (RXT / 2) @(posedge CLK);
        #1;
        chk("rx_timeout_early", 32'(ERR_FLAGS[0]), 0);
        repeat (RXT / 2 + 1) @(posedge CLK);
        #1;
        chk("rx_timeout_flag", 32'(ERR_FLAGS[0]), 1);
        chk("rx_timeout_idle", 32'(BUSY), 0);
        exp_err[0] = 1'b1;
        run_pkt("a", 32'd8, 32'd3, 1, 0);

        run_pkt("d", 32'd14, 32'd2, EXT + 2, 1);

        tx_mode = 2;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                c = 8'($urandom);
                while (is_legal(c)) c = 8'($urandom);
            end else begin
                c = legal_set[$urandom_range(0, 10)];
            end
            run_pkt(c, $urandom, 32'($urandom_range(0, 40)), $urandom_range(1, 6), 0);
        end

        tx_mode = 0;
        send_bytes("x", 32'h0102_0304, 32'h0506_0708, 4);
        UART_RX = 8'h05;
        UART_RX_valid = 1'b1;
        @(posedge CLK);
        #1;
        apply_reset();
        #1;
        check_zero("rst_mid_rx");
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        run_pkt("a", 32'd100, 32'd23, 2, 0);

        tx_limit = tx_xfers + 1;
        tx_mode  = 5;
        expect_pkt("x", 32'hA5A5_0000, 32'h0000_5A5A, 1, 0, r);
        send_bytes("x", 32'hA5A5_0000, 32'h0000_5A5A, 9);
        k = 0;
        do begin @(posedge CLK); #1; k++; end
            while (!(tx_xfers == tx_limit && UART_TX_valid) && k < 500);
        if (k >= 500) note_fail("wait_tx_first");
        @(posedge CLK);
        #1;
        chk("mid_tx_valid", 32'(UART_TX_valid), 1);
        apply_reset();
        #1;
        check_zero("rst_mid_tx");
        tx_mode = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        run_pkt("m", 32'd7, 32'd6, 1, 0);

        repeat (5) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
